// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared types and constants for the iterative RV32M multiply/divide unit.
//   - MULDIV_OP_*   : RV32M funct3 encodings of the eight ops
//   - IDLE/CALC/DONE: sequencer states
//   - MULDIV_XLEN, MULDIV_REG_ADDR_W, MULDIV_CNT_W: default widths
//   Helper functions classify an op (divide family, operand signedness).
package muldiv_pkg;

    localparam int MULDIV_XLEN       = 32;
    localparam int MULDIV_REG_ADDR_W = 5;
    localparam int MULDIV_CNT_W      = $clog2(MULDIV_XLEN);

    typedef enum logic [2:0] {
        MULDIV_OP_MUL    = 3'd0,
        MULDIV_OP_MULH   = 3'd1,
        MULDIV_OP_MULHSU = 3'd2,
        MULDIV_OP_MULHU  = 3'd3,
        MULDIV_OP_DIV    = 3'd4,
        MULDIV_OP_DIVU   = 3'd5,
        MULDIV_OP_REM    = 3'd6,
        MULDIV_OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    // funct3 bit 2 selects the divide/remainder family
    function automatic logic muldiv_op_is_div(input muldiv_op_e op);
        logic [2:0] code;
        code = op;
        return code[2];
    endfunction

    // Operand A is treated as signed
    function automatic logic muldiv_a_signed(input muldiv_op_e op);
        logic res;
        case (op)
            MULDIV_OP_MUL, MULDIV_OP_MULH, MULDIV_OP_MULHSU,
            MULDIV_OP_DIV, MULDIV_OP_REM: res = 1'b1;
            default:                      res = 1'b0;
        endcase
        return res;
    endfunction

    // Operand B is treated as signed
    function automatic logic muldiv_b_signed(input muldiv_op_e op);
        logic res;
        case (op)
            MULDIV_OP_MUL, MULDIV_OP_MULH,
            MULDIV_OP_DIV, MULDIV_OP_REM: res = 1'b1;
            default:                      res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/muldiv_operand_cond.sv
// muldiv_operand_cond
//   Combinational sign handling shared by operand conditioning and result fix-up.
//   Ports:
//     data      in  W  value to condition
//     signed_en in  1  treat data as two's-complement signed
//     neg_en    in  1  request an extra negation (result fix-up)
//     sign      out 1  sign of data when signed_en, else 0
//     value     out W  data negated when (sign ^ neg_en), else data
//   With neg_en = 0 this yields the magnitude of a signed operand; with
//   signed_en = 0 it is a plain conditional negate.
module muldiv_operand_cond #(
    parameter int W = 32
) (
    input  logic [W-1:0] data,
    input  logic         signed_en,
    input  logic         neg_en,
    output logic         sign,
    output logic [W-1:0] value
);

    logic negate_s;

    assign sign     = signed_en & data[W-1];
    assign negate_s = sign ^ neg_en;
    // -2^(W-1) maps to itself, which is the correct unsigned magnitude
    assign value    = negate_s ? ((~data) + W'(1)) : data;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide unit between register-file read ports and
//   its write port. One radix-2 shift-add multiplier / restoring divider is
//   shared by all eight ops, one op in flight.
//   Ports:
//     clock      in   1           rising-edge clock
//     rst        in   1           asynchronous active-high reset
//     start      in   1           request, accepted in IDLE or DONE
//     op         in   3           RV32M funct3
//     rs1_data   in   XLEN        multiplicand / dividend
//     rs2_data   in   XLEN        multiplier / divisor
//     rd_addr    in   REG_ADDR_W  destination register
//     busy       out  1           op in progress, start ignored
//     done       out  1           one-cycle completion pulse
//     result     out  XLEN        result, held until overwritten
//     result_reg out  REG_ADDR_W  destination captured with the op
//     result_we  out  1           done for a non-zero destination
//   Build option: define MULDIV_DIV_EN to build the divider. Without it,
//   ops 4-7 complete one cycle after acceptance with result 0.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN       = MULDIV_XLEN,
    parameter int REG_ADDR_W = MULDIV_REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  busy,
    output logic                  done,
    output logic [XLEN-1:0]       result,
    output logic [REG_ADDR_W-1:0] result_reg,
    output logic                  result_we
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    muldiv_state_e          state_r, state_s;
    muldiv_op_e             op_in_s, op_r;
    logic                   accept_s;
    logic                   a_signed_s, b_signed_s;
    logic                   sign_a_s, sign_b_s;
    logic [XLEN-1:0]        mag_a_s, mag_b_s;
    logic                   in_div_s;
    logic                   byp_s;
    logic [XLEN-1:0]        byp_val_s;

    logic [REG_ADDR_W-1:0]  rd_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   fin_r;
    logic                   byp_r;
    logic                   neg_q_r;
    logic                   neg_r_r;
    logic [XLEN-1:0]        opnd_r;
    logic [XLEN-1:0]        hi_r, lo_r;

    logic [XLEN:0]          mul_sum_s;
    logic [XLEN-1:0]        step_hi_s, step_lo_s;
`ifdef MULDIV_DIV_EN
    logic [XLEN:0]          div_shift_s, div_diff_s;
`endif

    logic [2*XLEN-1:0]      fix_q_s;
    logic [XLEN-1:0]        fix_r_s;
    logic                   fix_q_sign_unused_s, fix_r_sign_unused_s;
    logic [XLEN-1:0]        final_s;

    logic                   busy_r, done_r, we_r;
    logic [XLEN-1:0]        result_r;
    logic [REG_ADDR_W-1:0]  result_reg_r;

    assign op_in_s    = muldiv_op_e'(op);
    assign a_signed_s = muldiv_a_signed(op_in_s);
    assign b_signed_s = muldiv_b_signed(op_in_s);
    assign in_div_s   = muldiv_op_is_div(op_in_s);
    assign accept_s   = start & ((state_r == IDLE) | (state_r == DONE));

    muldiv_operand_cond #(.W(XLEN)) u_cond_a (
        .data      (rs1_data),
        .signed_en (a_signed_s),
        .neg_en    (1'b0),
        .sign      (sign_a_s),
        .value     (mag_a_s)
    );

    muldiv_operand_cond #(.W(XLEN)) u_cond_b (
        .data      (rs2_data),
        .signed_en (b_signed_s),
        .neg_en    (1'b0),
        .sign      (sign_b_s),
        .value     (mag_b_s)
    );

    // Quotient low bits of -{R,Q} equal -Q, so one wide negator serves both
    // the 2*XLEN product and the quotient.
    muldiv_operand_cond #(.W(2*XLEN)) u_fix_q (
        .data      ({hi_r, lo_r}),
        .signed_en (1'b0),
        .neg_en    (neg_q_r),
        .sign      (fix_q_sign_unused_s),
        .value     (fix_q_s)
    );

    muldiv_operand_cond #(.W(XLEN)) u_fix_r (
        .data      (hi_r),
        .signed_en (1'b0),
        .neg_en    (neg_r_r),
        .sign      (fix_r_sign_unused_s),
        .value     (fix_r_s)
    );

    // Detect ops that complete without iterating and pick their result
    always_comb begin
        byp_s     = 1'b0;
        byp_val_s = {XLEN{1'b0}};
`ifdef MULDIV_DIV_EN
        if (in_div_s) begin
            if (rs2_data == {XLEN{1'b0}}) begin
                byp_s = 1'b1;
                if ((op_in_s == MULDIV_OP_DIV) || (op_in_s == MULDIV_OP_DIVU)) begin
                    byp_val_s = {XLEN{1'b1}};
                end else begin
                    byp_val_s = rs1_data;
                end
            end else if (a_signed_s && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                         (rs2_data == {XLEN{1'b1}})) begin
                byp_s = 1'b1;
                if (op_in_s == MULDIV_OP_DIV) begin
                    byp_val_s = rs1_data;
                end else begin
                    byp_val_s = {XLEN{1'b0}};
                end
            end else begin
                byp_s = 1'b0;
            end
        end else begin
            byp_s = 1'b0;
        end
`else
        if (in_div_s) begin
            byp_s = 1'b1;
        end else begin
            byp_s = 1'b0;
        end
`endif
    end

    assign mul_sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
`ifdef MULDIV_DIV_EN
    assign div_shift_s = {hi_r, lo_r[XLEN-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opnd_r};
`endif

    // One iteration of the shared datapath: shift-add or restoring step
    always_comb begin
        step_hi_s = hi_r;
        step_lo_s = lo_r;
        if (muldiv_op_is_div(op_r)) begin
`ifdef MULDIV_DIV_EN
            // no borrow out means the trial subtraction fits: keep it, quotient bit 1
            if (!div_diff_s[XLEN]) begin
                step_hi_s = div_diff_s[XLEN-1:0];
                step_lo_s = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[XLEN-1:0];
                step_lo_s = {lo_r[XLEN-2:0], 1'b0};
            end
`else
            step_hi_s = hi_r;
            step_lo_s = lo_r;
`endif
        end else begin
            {step_hi_s, step_lo_s} = {mul_sum_s, lo_r[XLEN-1:1]};
        end
    end

    // Select the architectural result from the fixed-up datapath
    always_comb begin
        final_s = {XLEN{1'b0}};
        if (byp_r) begin
            final_s = lo_r;
        end else begin
            case (op_r)
                MULDIV_OP_MUL:    final_s = fix_q_s[XLEN-1:0];
                MULDIV_OP_MULH,
                MULDIV_OP_MULHSU,
                MULDIV_OP_MULHU:  final_s = fix_q_s[2*XLEN-1:XLEN];
                MULDIV_OP_DIV,
                MULDIV_OP_DIVU:   final_s = fix_q_s[XLEN-1:0];
                MULDIV_OP_REM,
                MULDIV_OP_REMU:   final_s = fix_r_s;
                default:          final_s = {XLEN{1'b0}};
            endcase
        end
    end

    // Sequencer next-state
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (fin_r) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (accept_s) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture and iterative datapath registers
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            op_r    <= MULDIV_OP_MUL;
            rd_r    <= {REG_ADDR_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            fin_r   <= 1'b0;
            byp_r   <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            opnd_r  <= {XLEN{1'b0}};
            hi_r    <= {XLEN{1'b0}};
            lo_r    <= {XLEN{1'b0}};
        end else if (accept_s) begin
            op_r  <= op_in_s;
            rd_r  <= rd_addr;
            cnt_r <= CNT_LAST;
            hi_r  <= {XLEN{1'b0}};
            if (byp_s) begin
                // bypassed ops finish on the next edge with the value parked in lo_r
                fin_r   <= 1'b1;
                byp_r   <= 1'b1;
                neg_q_r <= 1'b0;
                neg_r_r <= 1'b0;
                opnd_r  <= {XLEN{1'b0}};
                lo_r    <= byp_val_s;
            end else if (in_div_s) begin
                fin_r   <= 1'b0;
                byp_r   <= 1'b0;
                neg_q_r <= sign_a_s ^ sign_b_s;
                neg_r_r <= sign_a_s;
                opnd_r  <= mag_b_s;
                lo_r    <= mag_a_s;
            end else begin
                fin_r   <= 1'b0;
                byp_r   <= 1'b0;
                neg_q_r <= sign_a_s ^ sign_b_s;
                neg_r_r <= 1'b0;
                opnd_r  <= mag_a_s;
                lo_r    <= mag_b_s;
            end
        end else if ((state_r == CALC) && !fin_r) begin
            hi_r <= step_hi_s;
            lo_r <= step_lo_s;
            if (cnt_r == {CNT_W{1'b0}}) begin
                fin_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end
    end

    // Registered outputs; result is loaded on the edge that enters DONE
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            we_r         <= 1'b0;
            result_r     <= {XLEN{1'b0}};
            result_reg_r <= {REG_ADDR_W{1'b0}};
        end else begin
            busy_r <= (state_s == CALC);
            done_r <= (state_s == DONE);
            we_r   <= (state_s == DONE) && (rd_r != {REG_ADDR_W{1'b0}});
            if ((state_r == CALC) && fin_r) begin
                result_r     <= final_s;
                result_reg_r <= rd_r;
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign result_we  = we_r;
    assign result     = result_r;
    assign result_reg = result_reg_r;

endmodule
